router_fifo_param: RTL and testbench

Parametrised packet-aware FIFO for the router output channels, replacing the fixed 16x8 channel FIFO. Buffers header, payload and parity bytes written by the router FSM and tags each word with a header flag. It tracks the remaining length of the packet being read and flags packet completion, overflow attempts and truncated packets. One instance sits between the router register stage and each output port; width, depth and header-length field position are generics.

---
 rtl/router_fifo_param.sv | 95 +++++++++
 tb/tb_router_fifo_param.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/router_fifo_param.sv
// router_fifo_param: packet-aware output channel FIFO. Each entry carries a header flag
// so the read side can track the remaining packet length and flag completion and errors.
module router_fifo_param #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int LEN_LSB      = 2,
    parameter int AFULL_THRESH = DEPTH - 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    soft_rst,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    we,
    input  logic                    lfd_state,
    input  logic                    re,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    dout_valid,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    pkt_active,
    output logic                    pkt_done,
    output logic                    ovf_err,
    output logic                    hdr_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = DATA_WIDTH - LEN_LSB;
    localparam int CW = LW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_P = PW'(AFULL_THRESH);

    logic [DATA_WIDTH:0]  mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        pkt_cnt;
    logic                 wr_ok;
    logic                 rd_ok;
    logic [DATA_WIDTH:0]  rd_word;
    logic                 rd_hdr;
    logic [LW-1:0]        rd_len;

    assign count       = wr_ptr - rd_ptr;
    assign empty       = (count == '0);
    assign full        = (count == DEPTH_P);
    assign almost_full = (count >= AFULL_P);
    assign pkt_active  = (pkt_cnt != '0);

    assign wr_ok   = we && !full;
    assign rd_ok   = re && !empty;
    assign rd_word = mem[rd_ptr[AW-1:0]];
    assign rd_hdr  = rd_word[DATA_WIDTH];
    assign rd_len  = rd_word[DATA_WIDTH-1:LEN_LSB];

    // Storage has no reset; a flush or reset cycle must still suppress the write.
    always_ff @(posedge clk) begin
        if (rst && !soft_rst && wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= {lfd_state, din};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || soft_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pkt_cnt    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            pkt_done   <= 1'b0;
            ovf_err    <= 1'b0;
            hdr_err    <= 1'b0;
        end else begin
            dout_valid <= rd_ok;
            pkt_done   <= 1'b0;
            hdr_err    <= 1'b0;
            ovf_err    <= we && full;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
                dout   <= rd_word[DATA_WIDTH-1:0];
                // Header reload counts payload plus the trailing parity byte.
                if (rd_hdr) begin
                    pkt_cnt <= {1'b0, rd_len} + CW'(1);
                    hdr_err <= (pkt_cnt != '0);
                end else if (pkt_cnt != '0) begin
                    pkt_cnt  <= pkt_cnt - CW'(1);
                    pkt_done <= (pkt_cnt == CW'(1));
                end
            end
        end
    end
endmodule

// File: tb/tb_router_fifo_param.sv
// tb_router_fifo_param: directed and random stimulus against a queue-based packet model,
// on a default 16x8 instance and an 8-deep 16-bit instance.
module tb_router_fifo_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, soft_rst, we, re, lfd_state;
    logic [7:0]  din, dout;
    logic        dout_valid, empty, full, almost_full, pkt_active, pkt_done, ovf_err, hdr_err;
    logic [4:0]  count;

    logic        we_b, re_b;
    logic [15:0] din_b, dout_b;
    logic        dout_valid_b, empty_b, full_b, almost_full_b, pkt_active_b, pkt_done_b;
    logic        ovf_err_b, hdr_err_b;
    logic [3:0]  count_b;

    int checks = 0;
    int failures = 0;

    logic [8:0]  q[$];
    int          exp_pkt;
    logic [7:0]  exp_dout;
    bit          exp_valid, exp_done, exp_ovf, exp_hdr;

    logic [15:0] qb[$];
    logic [15:0] exp_dout_b;
    bit          exp_valid_b, exp_ovf_b;

    router_fifo_param u_dut (
        .clk(clk), .rst(rst), .soft_rst(soft_rst), .din(din), .we(we),
        .lfd_state(lfd_state), .re(re), .dout(dout), .dout_valid(dout_valid),
        .empty(empty), .full(full), .almost_full(almost_full), .count(count),
        .pkt_active(pkt_active), .pkt_done(pkt_done), .ovf_err(ovf_err), .hdr_err(hdr_err)
    );

    router_fifo_param #(.DATA_WIDTH(16), .DEPTH(8), .LEN_LSB(2)) u_dut_b (
        .clk(clk), .rst(rst), .soft_rst(1'b0), .din(din_b), .we(we_b),
        .lfd_state(1'b0), .re(re_b), .dout(dout_b), .dout_valid(dout_valid_b),
        .empty(empty_b), .full(full_b), .almost_full(almost_full_b), .count(count_b),
        .pkt_active(pkt_active_b), .pkt_done(pkt_done_b), .ovf_err(ovf_err_b),
        .hdr_err(hdr_err_b)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from the packet rules, using pre-edge queue state.
    task automatic model_a(input bit w, input bit r, input bit lfd, input bit s, input logic [7:0] d);
        logic [8:0] item;
        bit rd, wr;
        exp_done = 0;
        exp_hdr  = 0;
        exp_ovf  = 0;
        if (s) begin
            q.delete();
            exp_pkt = 0;
            exp_dout = 8'h00;
            exp_valid = 0;
            return;
        end
        exp_ovf = w && (q.size() == 16);
        rd = r && (q.size() != 0);
        wr = w && (q.size() != 16);
        exp_valid = rd;
        if (rd) begin
            item = q.pop_front();
            exp_dout = item[7:0];
            if (item[8]) begin
                exp_hdr = (exp_pkt != 0);
                exp_pkt = int'(item[7:2]) + 1;
            end else if (exp_pkt != 0) begin
                exp_pkt--;
                exp_done = (exp_pkt == 0);
            end
        end
        if (wr) q.push_back({lfd, d});
    endtask

    task automatic model_b(input bit w, input bit r, input logic [15:0] d);
        bit rd, wr;
        exp_ovf_b = w && (qb.size() == 8);
        rd = r && (qb.size() != 0);
        wr = w && (qb.size() != 8);
        exp_valid_b = rd;
        if (rd) exp_dout_b = qb.pop_front();
        if (wr) qb.push_back(d);
    endtask

    task automatic check_output();
        check_val("dout", 32'(dout), 32'(exp_dout));
        check_val("dout_valid", 32'(dout_valid), 32'(exp_valid));
        check_val("count", 32'(count), 32'(q.size()));
        check_val("empty", 32'(empty), 32'(q.size() == 0));
        check_val("full", 32'(full), 32'(q.size() == 16));
        check_val("almost_full", 32'(almost_full), 32'(q.size() >= 14));
        check_val("pkt_active", 32'(pkt_active), 32'(exp_pkt != 0));
        check_val("pkt_done", 32'(pkt_done), 32'(exp_done));
        check_val("ovf_err", 32'(ovf_err), 32'(exp_ovf));
        check_val("hdr_err", 32'(hdr_err), 32'(exp_hdr));
    endtask

    task automatic check_output_b();
        check_val("b_dout", 32'(dout_b), 32'(exp_dout_b));
        check_val("b_dout_valid", 32'(dout_valid_b), 32'(exp_valid_b));
        check_val("b_count", 32'(count_b), 32'(qb.size()));
        check_val("b_empty", 32'(empty_b), 32'(qb.size() == 0));
        check_val("b_full", 32'(full_b), 32'(qb.size() == 8));
        check_val("b_almost_full", 32'(almost_full_b), 32'(qb.size() >= 6));
        check_val("b_ovf_err", 32'(ovf_err_b), 32'(exp_ovf_b));
        check_val("b_pkt_active", 32'(pkt_active_b), 32'(0));
    endtask

    task automatic apply_stimulus(input bit w, input bit r, input bit lfd, input bit s,
                                  input logic [7:0] d);
        @(negedge clk);
        rst = 1'b1; we = w; re = r; lfd_state = lfd; soft_rst = s; din = d;
        we_b = 1'b0; re_b = 1'b0;
        model_a(w, r, lfd, s, d);
        model_b(1'b0, 1'b0, 16'h0);
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic apply_b(input bit w, input bit r, input logic [15:0] d);
        @(negedge clk);
        rst = 1'b1; we = 1'b0; re = 1'b0; soft_rst = 1'b0; we_b = w; re_b = r; din_b = d;
        model_a(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        model_b(w, r, d);
        @(posedge clk);
        #1;
        check_output_b();
    endtask

    initial begin
        rst = 1'b0; soft_rst = 1'b0; we = 1'b0; re = 1'b0; lfd_state = 1'b0; din = 8'h00;
        we_b = 1'b0; re_b = 1'b0; din_b = 16'h0;
        @(negedge clk);
        @(posedge clk);
        #1;
        q.delete(); exp_pkt = 0; exp_dout = 0; exp_valid = 0;
        exp_done = 0; exp_ovf = 0; exp_hdr = 0;
        qb.delete(); exp_dout_b = 0; exp_valid_b = 0; exp_ovf_b = 0;
        $display("[TB] reset");
        check_output();
        check_output_b();

        $display("[TB] fill, overflow, drain");
        for (int i = 1; i <= 16; i++) apply_stimulus(1, 0, 0, 0, 8'(i));
        apply_stimulus(1, 0, 0, 0, 8'hFF);
        for (int i = 0; i < 16; i++) apply_stimulus(0, 1, 0, 0, 8'h00);

        $display("[TB] full packet len 14");
        apply_stimulus(1, 0, 1, 0, 8'h39);
        for (int i = 0; i < 15; i++) apply_stimulus(1, 0, 0, 0, 8'($urandom));
        for (int i = 0; i < 16; i++) apply_stimulus(0, 1, 0, 0, 8'h00);

        $display("[TB] simultaneous read/write at full and empty");
        for (int i = 0; i < 16; i++) apply_stimulus(1, 0, 0, 0, 8'($urandom));
        apply_stimulus(1, 1, 0, 0, 8'hAA);
        for (int i = 0; i < 15; i++) apply_stimulus(0, 1, 0, 0, 8'h00);
        apply_stimulus(1, 1, 0, 0, 8'h5C);
        apply_stimulus(0, 1, 0, 0, 8'h00);

        $display("[TB] truncated packet");
        apply_stimulus(1, 0, 1, 0, 8'h39);
        for (int i = 0; i < 5; i++) apply_stimulus(1, 0, 0, 0, 8'($urandom));
        apply_stimulus(1, 0, 1, 0, 8'h39);
        for (int i = 0; i < 7; i++) apply_stimulus(0, 1, 0, 0, 8'h00);

        $display("[TB] soft reset mid-packet");
        for (int i = 0; i < 7; i++) apply_stimulus(1, 0, 0, 0, 8'($urandom));
        apply_stimulus(1, 1, 0, 1, 8'h77);
        apply_stimulus(1, 0, 0, 0, 8'h42);
        apply_stimulus(0, 1, 0, 0, 8'h00);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            apply_stimulus($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5,
                           $urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0,
                           8'($urandom));
        end

        $display("[TB] 8-deep 16-bit instance, pointer wrap");
        for (int round = 0; round < 5; round++) begin
            for (int i = 0; i < 8; i++) apply_b(1, 0, 16'($urandom));
            apply_b(1, 0, 16'hDEAD);
            for (int i = 0; i < 8; i++) apply_b(0, 1, 16'h0);
        end
        for (int i = 0; i < 100; i++) begin
            apply_b($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
